// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: a + b + cin, split into STAGES chunks of WIDTH/STAGES bits.
// One chunk is added per stage and the carry ripples forward through registers.
// valid/ready handshake on both sides, 1 op/cycle, stalls cleanly under backpressure.
// Optional feature macro: PCA_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_chunk_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_chunk_adder: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_chunk_adder: WIDTH must be a multiple of STAGES");
  end

  // Per-stage state: valid, carry, partial result, operands carried along
  logic [STAGES-1:0] v;
  logic              c    [STAGES];
  logic [WIDTH-1:0]  res  [STAGES];
  logic [WIDTH-1:0]  opa  [STAGES];
  logic [WIDTH-1:0]  opb  [STAGES];

  // Next-state values presented to each stage
  logic [STAGES-1:0] nv;
  logic              nc   [STAGES];
  logic [WIDTH-1:0]  nres [STAGES];
  logic [WIDTH-1:0]  na   [STAGES];
  logic [WIDTH-1:0]  nb   [STAGES];
  logic              novf;

  logic [STAGES-1:0] adv;

  // Advance enables: a stage may load if it is empty or some stage downstream
  // of it is empty or the consumer is taking a result. Accumulated from the
  // output end so adv never feeds back on itself.
  always_comb begin
    logic ok;
    ok  = out_ready;
    adv = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ok = ok || !v[STAGES-1-i];
      adv[STAGES-1-i] = ok;
    end
  end

  // Chunk adders: stage k adds chunk k of its source operands plus the incoming carry
  always_comb begin
    logic [WIDTH-1:0] sa, sb, sr;
    logic             sc;
    logic [CW:0]      ch;
    sa   = '0;
    sb   = '0;
    sr   = '0;
    sc   = 1'b0;
    ch   = '0;
    nv   = '0;
    novf = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sa    = a;
        sb    = b;
        sc    = cin;
        sr    = '0;
        nv[k] = in_valid;
      end else begin
        sa    = opa[k-1];
        sb    = opb[k-1];
        sc    = c[k-1];
        sr    = res[k-1];
        nv[k] = v[k-1];
      end
      ch = {1'b0, sa[k*CW +: CW]} + {1'b0, sb[k*CW +: CW]} + {{CW{1'b0}}, sc};
      sr[k*CW +: CW] = ch[CW-1:0];
      nres[k] = sr;
      nc[k]   = ch[CW];
      na[k]   = sa;
      nb[k]   = sb;
    end
    // Carry into the MSB is recovered as a^b^sum at that bit; XOR with carry out
    novf = sa[WIDTH-1] ^ sb[WIDTH-1] ^ sr[WIDTH-1] ^ ch[CW];
  end

  // Stage registers: valid follows adv; payload loads only behind a valid op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        c[k]   <= 1'b0;
        res[k] <= '0;
        opa[k] <= '0;
        opb[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= nv[k];
          if (nv[k]) begin
            c[k]   <= nc[k];
            res[k] <= nres[k];
            opa[k] <= na[k];
            opb[k] <= nb[k];
          end
        end
      end
    end
  end

`ifdef PCA_OVF_EN
  logic ovf_q;

  // Overflow flag registered alongside the last-stage sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[STAGES-1] && nv[STAGES-1]) begin
      ovf_q <= novf;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = novf;
`endif

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign sum       = res[STAGES-1];
  assign cout      = c[STAGES-1];

endmodule
